// File: rtl/hbm_sweep_pkg.sv
// Shared types and helpers for the gate sweep engine: FSM states, pair address
// construction, config legality and amplitude field slicing.
package hbm_sweep_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } sweep_state_t;

  // Helpers work on 32-bit addresses; designs are limited to 32 qubits.
  localparam int unsigned MaxQubits = 32;
  localparam int unsigned AmpHalfW  = 32;

  // Insert a zero at bit t of j: the a0 address of pair j for target t.
  function automatic logic [31:0] pair_base(input logic [31:0] j, input logic [5:0] t);
    logic [31:0] lo_mask;
    lo_mask = (32'd1 << t) - 32'd1;
    return ((j >> t) << (t + 6'd1)) | (j & lo_mask);
  endfunction

  function automatic logic cfg_legal(input int unsigned nq, input int unsigned t,
                                     input int unsigned c, input logic ctrl_en,
                                     input int unsigned max_q);
    return !(nq == 0 || nq > max_q || t >= nq || (ctrl_en && (c >= nq || c == t)));
  endfunction

  function automatic logic [AmpHalfW-1:0] amp_re(input logic [2*AmpHalfW-1:0] a);
    return a[2*AmpHalfW-1:AmpHalfW];
  endfunction

  function automatic logic [AmpHalfW-1:0] amp_im(input logic [2*AmpHalfW-1:0] a);
    return a[AmpHalfW-1:0];
  endfunction

endpackage

// File: rtl/hbm_gate_sweeper_if.sv
// Memory read, PE array and write-back buses of the gate sweeper.
// master = sweeper side, slave = memory channel / PE array side.
interface hbm_gate_sweeper_if #(
  parameter int unsigned N_QUBITS = 30,
  parameter int unsigned AMP_W    = 64
);
  logic                rd_req_valid;
  logic                rd_req_ready;
  logic [N_QUBITS-1:0] rd_req_addr;
  logic                rd_rsp_valid;
  logic [AMP_W-1:0]    rd_rsp_data;

  logic                pe_req_valid;
  logic                pe_req_ready;
  logic [AMP_W-1:0]    pe_req_a0;
  logic [AMP_W-1:0]    pe_req_a1;
  logic                pe_rsp_valid;
  logic                pe_rsp_ready;
  logic [AMP_W-1:0]    pe_rsp_b0;
  logic [AMP_W-1:0]    pe_rsp_b1;

  logic                wr_valid;
  logic                wr_ready;
  logic [N_QUBITS-1:0] wr_addr;
  logic [AMP_W-1:0]    wr_data;

  modport master (
    output rd_req_valid, rd_req_addr,
    input  rd_req_ready, rd_rsp_valid, rd_rsp_data,
    output pe_req_valid, pe_req_a0, pe_req_a1, pe_rsp_ready,
    input  pe_req_ready, pe_rsp_valid, pe_rsp_b0, pe_rsp_b1,
    output wr_valid, wr_addr, wr_data,
    input  wr_ready
  );

  modport slave (
    input  rd_req_valid, rd_req_addr,
    output rd_req_ready, rd_rsp_valid, rd_rsp_data,
    input  pe_req_valid, pe_req_a0, pe_req_a1, pe_rsp_ready,
    output pe_req_ready, pe_rsp_valid, pe_rsp_b0, pe_rsp_b1,
    input  wr_valid, wr_addr, wr_data,
    output wr_ready
  );
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; DEPTH must be a power of two >= 2.
// Read data is forced to zero while empty so the consumer sees clean outputs.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_full;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (i_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !i_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr] <= i_wdata;
  end

  // Producers rely on external credit limits; overrunning is a design bug.
  always_ff @(posedge i_clk) begin
    if (rst_n) assert (!(i_push && w_full && !w_pop));
  end

endmodule

// File: rtl/hbm_gate_sweeper.sv
// Gate sweep engine: enumerates target-qubit amplitude pairs, reads both halves,
// hands them to the PE array and writes the results back in place, in order.
module hbm_gate_sweeper
  import hbm_sweep_pkg::*;
#(
  parameter int unsigned N_QUBITS = 30,
  parameter int unsigned AMP_W    = 64,
  parameter int unsigned MAX_OUT  = 4,
  parameter int unsigned QW       = $clog2(N_QUBITS)
) (
  input  logic                pcie_clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [QW:0]         i_cfg_nq,
  input  logic [QW-1:0]       i_cfg_target,
  input  logic [QW-1:0]       i_cfg_ctrl,
  input  logic                i_cfg_ctrl_en,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output logic [N_QUBITS-1:0] o_pair_cnt,
  hbm_gate_sweeper_if.master  bus
);
  localparam int unsigned CW = $clog2(MAX_OUT) + 1;
  localparam logic [N_QUBITS-1:0] AllOnes = '1;
  localparam logic [QW:0] NqPlus1 = (QW+1)'(N_QUBITS + 1);

  sweep_state_t        r_state, w_state_next;
  logic [QW:0]         r_nq;
  logic [QW-1:0]       r_t;
  logic [QW-1:0]       r_c;
  logic                r_ctrl_en;
  logic [N_QUBITS-1:0] r_j, w_j_next;
  logic                r_beat, w_beat_next;
  logic [CW-1:0]       r_credits;
  logic [N_QUBITS-1:0] r_pair_cnt;
  logic                r_err, w_err_next;
  logic [AMP_W-1:0]    r_hold;
  logic                r_hold_vld;
  logic                r_wr_full;
  logic                r_wr_phase;
  logic [N_QUBITS-1:0] r_wr_a0;
  logic [AMP_W-1:0]    r_b0;
  logic [AMP_W-1:0]    r_b1;

  logic                w_accept;
  logic                w_addr_push;
  logic                w_credit_inc;
  logic                w_retire;
  logic [QW:0]         w_shamt;
  logic [N_QUBITS-1:0] w_jmax;
  logic [N_QUBITS-1:0] w_a0;
  logic [N_QUBITS-1:0] w_tbit;
  logic                w_skip;
  logic                w_last;
  logic                w_can_issue;
  logic                w_pair_push;
  logic                w_pair_empty;
  logic [2*AMP_W-1:0]  w_pair_dout;
  logic                w_pe_req_hs;
  logic                w_pe_rsp_hs;
  logic                w_wr_hs;
  logic                w_addr_empty;
  logic [N_QUBITS-1:0] w_addr_dout;

  // j runs 0 .. 2^(nq-1)-1
  assign w_shamt     = NqPlus1 - r_nq;
  assign w_jmax      = AllOnes >> w_shamt;
  assign w_a0        = N_QUBITS'(pair_base(32'(r_j), 6'(r_t)));
  assign w_tbit      = N_QUBITS'(1) << r_t;
  assign w_skip      = r_ctrl_en && !w_a0[r_c];
  assign w_last      = (r_j == w_jmax);
  assign w_can_issue = (r_credits < CW'(MAX_OUT));

  always_comb begin
    w_state_next     = r_state;
    w_j_next         = r_j;
    w_beat_next      = r_beat;
    w_err_next       = 1'b0;
    w_accept         = 1'b0;
    w_addr_push      = 1'b0;
    w_credit_inc     = 1'b0;
    bus.rd_req_valid = 1'b0;
    bus.rd_req_addr  = w_a0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          if (cfg_legal(32'(i_cfg_nq), 32'(i_cfg_target), 32'(i_cfg_ctrl), i_cfg_ctrl_en,
                        N_QUBITS)) begin
            w_accept     = 1'b1;
            w_state_next = StRun;
          end else begin
            w_err_next = 1'b1;
          end
        end
      end
      StRun: begin
        if (!r_beat) begin
          if (w_skip) begin
            if (w_last) w_state_next = StDrain;
            else        w_j_next     = r_j + 1'b1;
          end else if (w_can_issue) begin
            bus.rd_req_valid = 1'b1;
            if (bus.rd_req_ready) begin
              w_addr_push  = 1'b1;
              w_credit_inc = 1'b1;
              w_beat_next  = 1'b1;
            end
          end
        end else begin
          bus.rd_req_valid = 1'b1;
          bus.rd_req_addr  = w_a0 | w_tbit;
          if (bus.rd_req_ready) begin
            w_beat_next = 1'b0;
            if (w_last) w_state_next = StDrain;
            else        w_j_next     = r_j + 1'b1;
          end
        end
      end
      StDrain: begin
        if (r_credits == '0 && !r_wr_full) w_state_next = StDone;
      end
      StDone: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge pcie_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_nq      <= '0;
      r_t       <= '0;
      r_c       <= '0;
      r_ctrl_en <= 1'b0;
      r_j       <= '0;
      r_beat    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_err   <= w_err_next;
      if (w_accept) begin
        r_nq      <= i_cfg_nq;
        r_t       <= i_cfg_target;
        r_c       <= i_cfg_ctrl;
        r_ctrl_en <= i_cfg_ctrl_en;
        r_j       <= '0;
        r_beat    <= 1'b0;
      end else begin
        r_j    <= w_j_next;
        r_beat <= w_beat_next;
      end
    end
  end

  always_ff @(posedge pcie_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credits  <= '0;
      r_pair_cnt <= '0;
    end else begin
      unique case ({w_credit_inc, w_retire})
        2'b10:   r_credits <= r_credits + 1'b1;
        2'b01:   r_credits <= r_credits - 1'b1;
        default: r_credits <= r_credits;
      endcase
      if (w_accept)      r_pair_cnt <= '0;
      else if (w_retire) r_pair_cnt <= r_pair_cnt + 1'b1;
    end
  end

  // Responses arrive in request order: first beat of a pair is a0, second a1.
  assign w_pair_push = bus.rd_rsp_valid && r_hold_vld;

  always_ff @(posedge pcie_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
    end else if (bus.rd_rsp_valid) begin
      if (!r_hold_vld) begin
        r_hold     <= bus.rd_rsp_data;
        r_hold_vld <= 1'b1;
      end else begin
        r_hold_vld <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .WIDTH (N_QUBITS),
    .DEPTH (MAX_OUT)
  ) u_addr_fifo (
    .i_clk   (pcie_clk),
    .rst_n   (rst_n),
    .i_push  (w_addr_push),
    .i_wdata (w_a0),
    .i_pop   (w_pe_rsp_hs),
    .o_rdata (w_addr_dout),
    .o_empty (w_addr_empty)
  );

  sync_fifo #(
    .WIDTH (2 * AMP_W),
    .DEPTH (MAX_OUT)
  ) u_pair_fifo (
    .i_clk   (pcie_clk),
    .rst_n   (rst_n),
    .i_push  (w_pair_push),
    .i_wdata ({r_hold, bus.rd_rsp_data}),
    .i_pop   (w_pe_req_hs),
    .o_rdata (w_pair_dout),
    .o_empty (w_pair_empty)
  );

  assign bus.pe_req_valid = !w_pair_empty;
  assign bus.pe_req_a0    = w_pair_dout[2*AMP_W-1:AMP_W];
  assign bus.pe_req_a1    = w_pair_dout[AMP_W-1:0];
  assign w_pe_req_hs      = bus.pe_req_valid && bus.pe_req_ready;

  // Only accept results while a sweep is active, so reset leaves ready low.
  assign bus.pe_rsp_ready = (r_state == StRun || r_state == StDrain) && !r_wr_full
                            && !w_addr_empty;
  assign w_pe_rsp_hs      = bus.pe_rsp_valid && bus.pe_rsp_ready;

  assign bus.wr_valid = r_wr_full;
  assign bus.wr_addr  = r_wr_phase ? (r_wr_a0 | w_tbit) : r_wr_a0;
  assign bus.wr_data  = r_wr_phase ? r_b1 : r_b0;
  assign w_wr_hs      = bus.wr_valid && bus.wr_ready;
  assign w_retire     = w_wr_hs && r_wr_phase;

  always_ff @(posedge pcie_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_full  <= 1'b0;
      r_wr_phase <= 1'b0;
      r_wr_a0    <= '0;
      r_b0       <= '0;
      r_b1       <= '0;
    end else if (w_pe_rsp_hs) begin
      r_wr_full  <= 1'b1;
      r_wr_phase <= 1'b0;
      r_wr_a0    <= w_addr_dout;
      r_b0       <= bus.pe_rsp_b0;
      r_b1       <= bus.pe_rsp_b1;
    end else if (w_wr_hs) begin
      if (!r_wr_phase) r_wr_phase <= 1'b1;
      else             r_wr_full  <= 1'b0;
    end
  end

  assign o_busy     = (r_state == StRun) || (r_state == StDrain);
  assign o_done     = (r_state == StDone);
  assign o_err      = r_err;
  assign o_pair_cnt = r_pair_cnt;

endmodule

// File: tb/tb_hbm_gate_sweeper.sv
// Directed bench for hbm_gate_sweeper with unit-latency memory and PE models.
module tb_hbm_gate_sweeper;
  import hbm_sweep_pkg::*;

  localparam int unsigned NQ = 30;
  localparam int unsigned AW = 64;

  logic          pcie_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [5:0]    cfg_nq = '0;
  logic [4:0]    cfg_target = '0;
  logic [4:0]    cfg_ctrl = '0;
  logic          cfg_ctrl_en = 1'b0;
  logic          busy, done, err;
  logic [NQ-1:0] pair_cnt;

  hbm_gate_sweeper_if #(.N_QUBITS(NQ), .AMP_W(AW)) bus ();

  hbm_gate_sweeper #(
    .N_QUBITS (NQ),
    .AMP_W    (AW),
    .MAX_OUT  (4)
  ) dut (
    .pcie_clk      (pcie_clk),
    .rst_n         (rst_n),
    .i_start       (start),
    .i_cfg_nq      (cfg_nq),
    .i_cfg_target  (cfg_target),
    .i_cfg_ctrl    (cfg_ctrl),
    .i_cfg_ctrl_en (cfg_ctrl_en),
    .o_busy        (busy),
    .o_done        (done),
    .o_err         (err),
    .o_pair_cnt    (pair_cnt),
    .bus           (bus)
  );

  always #5 pcie_clk = ~pcie_clk;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  logic [NQ-1:0]  rd_log[$];
  logic [NQ-1:0]  wr_addr_log[$];
  logic [AW-1:0]  wr_data_log[$];
  logic [127:0]   pe_q[$];
  logic           rd_pend = 1'b0;
  logic [NQ-1:0]  rd_pend_addr = '0;
  logic           pe_pend = 1'b0;
  logic [127:0]   pe_pend_val = '0;
  logic           pe_rsp_hs_prev = 1'b0;

  function automatic logic [AW-1:0] memval(input logic [NQ-1:0] a);
    return {32'h1000_0000 + 32'(a), 32'hA5A5_0000 ^ 32'(a)};
  endfunction

  function automatic logic [AW-1:0] pe_b0(input logic [AW-1:0] a);
    return {amp_im(a), amp_re(a)};
  endfunction

  function automatic logic [AW-1:0] pe_b1(input logic [AW-1:0] a);
    return {amp_re(a) + 32'd7, amp_im(a) ^ 32'h0000_FFFF};
  endfunction

  // Memory, PE and write sink models; handshakes seen here complete at the next posedge.
  always @(negedge pcie_clk) begin
    if (!rst_n) begin
      rd_pend = 1'b0;
      pe_pend = 1'b0;
      pe_rsp_hs_prev = 1'b0;
      pe_q.delete();
      bus.rd_rsp_valid = 1'b0;
      bus.rd_rsp_data  = '0;
      bus.pe_rsp_valid = 1'b0;
      bus.pe_rsp_b0    = '0;
      bus.pe_rsp_b1    = '0;
    end else begin
      if (done) done_cnt++;
      if (err)  err_cnt++;
      bus.rd_rsp_valid = rd_pend;
      bus.rd_rsp_data  = rd_pend ? memval(rd_pend_addr) : '0;
      rd_pend      = bus.rd_req_valid && bus.rd_req_ready;
      rd_pend_addr = bus.rd_req_addr;
      if (rd_pend) rd_log.push_back(bus.rd_req_addr);
      if (pe_rsp_hs_prev) void'(pe_q.pop_front());
      if (pe_pend) pe_q.push_back(pe_pend_val);
      pe_pend     = bus.pe_req_valid && bus.pe_req_ready;
      pe_pend_val = {pe_b0(bus.pe_req_a0), pe_b1(bus.pe_req_a1)};
      bus.pe_rsp_valid = (pe_q.size() != 0);
      if (bus.pe_rsp_valid) {bus.pe_rsp_b0, bus.pe_rsp_b1} = pe_q[0];
      pe_rsp_hs_prev = bus.pe_rsp_valid && bus.pe_rsp_ready;
      if (bus.wr_valid && bus.wr_ready) begin
        wr_addr_log.push_back(bus.wr_addr);
        wr_data_log.push_back(bus.wr_data);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    rd_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
  endtask

  task automatic start_sweep(input int nq, input int t, input int c, input logic en);
    @(negedge pcie_clk);
    start = 1'b1;
    cfg_nq = 6'(nq);
    cfg_target = 5'(t);
    cfg_ctrl = 5'(c);
    cfg_ctrl_en = en;
    @(negedge pcie_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string tag);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge pcie_clk);
      n++;
    end
    chk({tag, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
    repeat (3) @(negedge pcie_clk);
    chk({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  task automatic check_traffic(input string tag, input int exp[$]);
    logic [AW-1:0] want;
    chk({tag, "_rd_count"}, 64'(rd_log.size()), 64'(exp.size()));
    chk({tag, "_wr_count"}, 64'(wr_addr_log.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < rd_log.size()) chk($sformatf("%s_rd%0d", tag, i), 64'(rd_log[i]), 64'(exp[i]));
      if (i < wr_addr_log.size()) begin
        want = (i % 2 == 0) ? pe_b0(memval(NQ'(exp[i]))) : pe_b1(memval(NQ'(exp[i])));
        chk($sformatf("%s_wa%0d", tag, i), 64'(wr_addr_log[i]), 64'(exp[i]));
        chk($sformatf("%s_wd%0d", tag, i), wr_data_log[i], want);
      end
    end
  endtask

  task automatic illegal_case(input string tag, input int nq, input int t, input int c,
                              input logic en);
    int rd0 = rd_log.size();
    int e0 = err_cnt;
    start_sweep(nq, t, c, en);
    chk({tag, "_err_hi"}, 64'(err), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    @(negedge pcie_clk);
    chk({tag, "_err_lo"}, 64'(err), 64'd0);
    repeat (3) @(negedge pcie_clk);
    chk({tag, "_err_pulses"}, 64'(err_cnt - e0), 64'd1);
    chk({tag, "_no_rd"}, 64'(rd_log.size() - rd0), 64'd0);
    chk({tag, "_rd_valid"}, 64'(bus.rd_req_valid), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_pair_cnt"}, 64'(pair_cnt), 64'd0);
    chk({tag, "_rd_valid"}, 64'(bus.rd_req_valid), 64'd0);
    chk({tag, "_rd_addr"}, 64'(bus.rd_req_addr), 64'd0);
    chk({tag, "_pe_valid"}, 64'(bus.pe_req_valid), 64'd0);
    chk({tag, "_pe_a0"}, bus.pe_req_a0, 64'd0);
    chk({tag, "_pe_rsp_ready"}, 64'(bus.pe_rsp_ready), 64'd0);
    chk({tag, "_wr_valid"}, 64'(bus.wr_valid), 64'd0);
    chk({tag, "_wr_data"}, bus.wr_data, 64'd0);
  endtask

  initial begin
    int d0;
    int exp[$];
    bus.rd_req_ready = 1'b1;
    bus.pe_req_ready = 1'b1;
    bus.wr_ready     = 1'b1;
    repeat (3) @(negedge pcie_clk);
    check_all_zero("reset");
    @(posedge pcie_clk);
    #1 rst_n = 1'b1;

    // nq=3, t=0: sequential addresses
    clear_logs();
    d0 = done_cnt;
    start_sweep(3, 0, 0, 1'b0);
    chk("t0_busy_start", 64'(busy), 64'd1);
    wait_done(d0, 300, "t0");
    chk("t0_pair_cnt", 64'(pair_cnt), 64'd4);
    exp = '{0, 1, 2, 3, 4, 5, 6, 7};
    check_traffic("t0", exp);

    // nq=3, t=2: top-bit partner
    clear_logs();
    d0 = done_cnt;
    start_sweep(3, 2, 0, 1'b0);
    wait_done(d0, 300, "t2");
    chk("t2_pair_cnt", 64'(pair_cnt), 64'd4);
    exp = '{0, 4, 1, 5, 2, 6, 3, 7};
    check_traffic("t2", exp);

    // nq=3, t=1, controlled on qubit 0
    clear_logs();
    d0 = done_cnt;
    start_sweep(3, 1, 0, 1'b1);
    wait_done(d0, 300, "ctrl");
    chk("ctrl_pair_cnt", 64'(pair_cnt), 64'd2);
    exp = '{1, 3, 5, 7};
    check_traffic("ctrl", exp);

    // credit limit: PE stalled, only MAX_OUT pairs may be read
    clear_logs();
    @(posedge pcie_clk);
    #1 bus.pe_req_ready = 1'b0;
    d0 = done_cnt;
    start_sweep(4, 1, 0, 1'b0);
    repeat (50) @(negedge pcie_clk);
    chk("stall_rd_count", 64'(rd_log.size()), 64'd8);
    chk("stall_rd_valid", 64'(bus.rd_req_valid), 64'd0);
    chk("stall_pe_valid", 64'(bus.pe_req_valid), 64'd1);
    chk("stall_no_wr", 64'(wr_addr_log.size()), 64'd0);
    chk("stall_busy", 64'(busy), 64'd1);
    @(posedge pcie_clk);
    #1 bus.pe_req_ready = 1'b1;
    wait_done(d0, 600, "stall");
    chk("stall_pair_cnt", 64'(pair_cnt), 64'd8);
    exp = '{0, 2, 1, 3, 4, 6, 5, 7, 8, 10, 9, 11, 12, 14, 13, 15};
    check_traffic("stall", exp);

    illegal_case("ill_ctrl_eq_t", 3, 1, 1, 1'b1);
    illegal_case("ill_t_ge_nq", 3, 3, 0, 1'b0);
    illegal_case("ill_nq0", 0, 0, 0, 1'b0);

    // reset in the middle of an nq=5 sweep
    clear_logs();
    start_sweep(5, 0, 0, 1'b0);
    repeat (12) @(negedge pcie_clk);
    chk("rst_mid_busy", 64'(busy), 64'd1);
    @(posedge pcie_clk);
    #1 rst_n = 1'b0;
    #1 check_all_zero("rst_mid");
    repeat (3) @(negedge pcie_clk);
    clear_logs();
    repeat (3) @(negedge pcie_clk);
    chk("rst_hold_no_rd", 64'(rd_log.size()), 64'd0);
    @(posedge pcie_clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge pcie_clk);
    chk("rst_after_no_rd", 64'(rd_log.size()), 64'd0);
    d0 = done_cnt;
    start_sweep(2, 0, 0, 1'b0);
    wait_done(d0, 300, "post_rst");
    chk("post_rst_pair_cnt", 64'(pair_cnt), 64'd2);
    exp = '{0, 1, 2, 3};
    check_traffic("post_rst", exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
